// File: rtl/cordic_core.sv
// CORDIC rotation-mode core: turns a Q3.13 angle into Q2.14 cosine and sine
// with one micro-rotation per enabled clock edge, then holds the result.
module cordic_core #(
    parameter int ITERATIONS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic signed [15:0] angle,
    output logic signed [15:0] cos_out,
    output logic signed [15:0] sin_out,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    // Starting x is the CORDIC gain K = 0.607253 in Q2.14, so the result needs no post-scaling.
    localparam logic signed [15:0] X_INIT    = 16'sd9949;
    // Largest legal angle magnitude, pi/2 in Q3.13.
    localparam logic signed [15:0] ANGLE_MAX = 16'sd12868;
    localparam logic signed [15:0] ANGLE_MIN = -16'sd12868;
    localparam logic [3:0]         LAST_ITER = 4'(ITERATIONS - 1);

    state_t             state;
    state_t             state_next;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic signed [15:0] x_next;
    logic signed [15:0] y_next;
    logic signed [15:0] z_next;
    logic signed [15:0] z_init;
    logic signed [15:0] x_shift;
    logic signed [15:0] y_shift;
    logic [3:0]         iter;
    logic               step;
    logic               last_step;

    // atan(2^-i) in Q3.13, rounded half-up.
    function automatic logic signed [15:0] atan_entry(input logic [3:0] i);
        logic signed [15:0] t;
        case (i)
            4'd0:    t = 16'sd6434;
            4'd1:    t = 16'sd3798;
            4'd2:    t = 16'sd2007;
            4'd3:    t = 16'sd1019;
            4'd4:    t = 16'sd511;
            4'd5:    t = 16'sd256;
            4'd6:    t = 16'sd128;
            4'd7:    t = 16'sd64;
            4'd8:    t = 16'sd32;
            4'd9:    t = 16'sd16;
            4'd10:   t = 16'sd8;
            4'd11:   t = 16'sd4;
            4'd12:   t = 16'sd2;
            4'd13:   t = 16'sd1;
            4'd14:   t = 16'sd1;
            default: t = 16'sd0;
        endcase
        return t;
    endfunction

    // Clamp the incoming angle to +/- pi/2 so the rotation cannot overflow.
    always_comb begin
        z_init = angle;
        if (angle > ANGLE_MAX) begin
            z_init = ANGLE_MAX;
        end else if (angle < ANGLE_MIN) begin
            z_init = ANGLE_MIN;
        end
    end

    // One micro-rotation from the current registers; direction follows the sign of the residual angle.
    always_comb begin
        x_shift = x >>> iter;
        y_shift = y >>> iter;
        if (z >= 16'sd0) begin
            x_next = x - y_shift;
            y_next = y + x_shift;
            z_next = z - atan_entry(iter);
        end else begin
            x_next = x + y_shift;
            y_next = y - x_shift;
            z_next = z + atan_entry(iter);
        end
    end

    assign step      = (state == RUN) && en && !load;
    assign last_step = step && (iter == LAST_ITER);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: load restarts from any state, the final rotation moves RUN to FINISH.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = RUN;
        end else if (last_step) begin
            state_next = FINISH;
        end
    end

    // Datapath and result registers; outputs only move on the final rotation or on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            iter    <= '0;
            cos_out <= '0;
            sin_out <= '0;
            done    <= 1'b0;
        end else if (load) begin
            x    <= X_INIT;
            y    <= '0;
            z    <= z_init;
            iter <= '0;
            done <= 1'b0;
        end else if (step) begin
            x    <= x_next;
            y    <= y_next;
            z    <= z_next;
            iter <= iter + 4'd1;
            if (last_step) begin
                cos_out <= x_next;
                sin_out <= y_next;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cordic_core.md
CORDIC_CORE -- requirements
Module: cordic_core

Interface
REQ-001 The block SHALL have one parameter: ITERATIONS, default 16, number of micro-rotations performed; legal range 1..16.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-004 The block SHALL have port `rst`: input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port `load`: input, 1 bit; while high, the block initialises from `angle` and holds. It is driven by the upstream controller's output_rst.
REQ-006 The block SHALL have port `en`: input, 1 bit, iteration enable; driven by the upstream controller's output_en.
REQ-007 The block SHALL have port `angle`: input, 16 bits, signed Q3.13 radians.
REQ-008 The block SHALL have port `cos_out`: output, 16 bits, signed Q2.14 cosine result.
REQ-009 The block SHALL have port `sin_out`: output, 16 bits, signed Q2.14 sine result.
REQ-010 The block SHALL have port `done`: output, 1 bit; high when `cos_out`/`sin_out` hold the result for the last loaded angle. It is consumed by the upstream controller.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, RUN and FINISH.
REQ-012 Priority SHALL be `rst` > `load` > `en`.
REQ-013 On any edge with `load`=1:
- x:=9949 (K·2^14, K=0.607253), y:=0, z:=sat(angle), iter:=0, done:=0, state:=RUN.
- Applies in every state, including mid-RUN (abort and restart) and FINISH.
REQ-014 sat(angle) SHALL clamp `angle` to [-12868, +12868] (±π/2 in Q3.13); in-range values pass unchanged.
REQ-015 In RUN, each edge with `load`=0 and `en`=1 SHALL perform one micro-rotation i=iter:
- d=+1 if z>=0, else -1.
- x:=x − d·(y>>>i), y:=y + d·(x>>>i), z:=z − d·T[i], all evaluated with pre-edge values.
- iter:=iter+1.
REQ-016 Shifts SHALL be arithmetic (sign-extending).
REQ-017 x, y and z SHALL be 16-bit two's-complement registers with wrap-around arithmetic; no overflow is possible for saturated inputs.
REQ-018 T[0..15] SHALL be the constant table 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 0.
- T[i] = atan(2^-i)·2^13, rounded half-up.
REQ-019 In RUN, an edge with `en`=0 and `load`=0 SHALL hold all state; the result latency extends by one cycle per stalled edge.
REQ-020 On the edge performing iteration ITERATIONS−1, the block SHALL:
- Load `cos_out`:=x_next and `sin_out`:=y_next.
- Set `done`:=1 and state:=FINISH.
REQ-021 Result latency SHALL be exactly ITERATIONS enabled edges after the first edge with `load`=0; `done` is visible in the following cycle.
REQ-022 In FINISH, `done`, `cos_out` and `sin_out` SHALL hold until `load` or `rst`; `angle` changes are ignored without `load`.
REQ-023 `cos_out`/`sin_out` SHALL change only on the final-iteration edge or on reset.
- They keep the previous result during RUN and while `load` is high.
REQ-024 In IDLE (after reset, no `load` yet), the block SHALL hold with `done`=0 regardless of `en`.
REQ-025 Accuracy SHALL be |error| <= 4 LSB (Q2.14) versus ideal cos/sin for every saturated angle when ITERATIONS=16.

Reset
REQ-026 On an edge with `rst`=1, the block SHALL set:
- state:=IDLE.
- x, y, z, iter:=0.
- `cos_out`:=0, `sin_out`:=0, `done`:=0.
REQ-027 A reset mid-RUN SHALL abort the computation with no result update; `rst` overrides a simultaneous `load`.
REQ-028 No output SHALL be X after the first reset edge.

Verification
REQ-029 Scenario: `load` pulse with angle=0, then `en`=1 -> `done`=1 after 16 enabled edges; cos_out=16384±4, sin_out=0±4.
REQ-030 Scenario: angle=6434 (π/4) -> cos_out=sin_out=11585±4; angle=-6434 -> cos_out=11585±4, sin_out=-11585±4.
REQ-031 Scenario: angle=12868 -> cos_out=0±4, sin_out=16384±4; angle=20000 (saturated) -> identical result.
REQ-032 Scenario: `en`=0 for 5 edges mid-RUN -> `done` rises 5 cycles later than nominal, with the same result as an unstalled run.
REQ-033 Scenario: `load` re-asserted after iteration 8 with a new angle -> old result not published; `done` rises 16 enabled edges after `load` falls, with the new angle's result.
REQ-034 Scenario: `rst` asserted mid-RUN, and separately together with `load` -> next cycle `done`=0, outputs=0, state IDLE; no completion without a further `load`.
